// File: rtl/des_pkg.sv
// DES round-core shared definitions: permutation tables (1-based DES bit numbers),
// round count default, datapath typedefs and the round-control state encoding.
package des_pkg;

  localparam int unsigned DES_ROUNDS = 16;

  typedef logic [31:0] half_t;
  typedef logic [47:0] exp_t;
  typedef logic [55:0] key56_t;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} des_state_e;

  // Entry n-1 names the source DES bit for output DES bit n.
  localparam int unsigned IP_TABLE [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int unsigned FP_TABLE [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int unsigned E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

endpackage

// File: rtl/des_expansion.sv
// DES E-expansion: 32-bit half to 48 bits, duplicating the edge bits of each 4-bit group.
module des_expansion
  import des_pkg::*;
(
  input  half_t i_half,
  output exp_t  o_exp
);

  // DES bit n lives at vector index [W-n].
  for (genvar n = 1; n <= 48; n++) begin : g_e
    localparam int unsigned Src = 32 - E_TABLE[n-1];
    assign o_exp[6'(48 - n)] = i_half[5'(Src)];
  end

endmodule

// File: rtl/des_round_core.sv
// Registered DES round-state datapath: IP on load, Feistel swap per step using an
// externally computed f(R,K), E-expansion of R and the final block output.
// Optional feature macro: DES_FINAL_PERM_EN (applies FP to the swapped preoutput).
module des_round_core
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = DES_ROUNDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] block_in,
  input  key56_t      key_in,
  input  logic        step,
  input  half_t       f_in,
  output half_t       l_out,
  output half_t       r_out,
  output exp_t        e_out,
  output key56_t      key_out,
  output logic [4:0]  round,
  output logic        busy,
  output logic        done,
  output logic [63:0] block_out
);

  localparam logic [4:0] RoundLast = 5'(ROUNDS - 1);

  des_state_e r_state;
  des_state_e w_state_d;
  half_t      r_l;
  half_t      r_r;
  key56_t     r_key;
  logic [4:0] r_round;
  logic [63:0] w_ip;
  logic [63:0] w_preout;
  logic        w_step;

  for (genvar n = 1; n <= 64; n++) begin : g_ip
    localparam int unsigned Src = 64 - IP_TABLE[n-1];
    assign w_ip[6'(64 - n)] = block_in[6'(Src)];
  end

  // load has priority; steps only count while a block is in flight.
  assign w_step = step && (r_state == StBusy) && !load;

  // Round-control next state.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (load) w_state_d = StBusy;
      StBusy: begin
        if (load) w_state_d = StBusy;
        else if (step && (r_round == RoundLast)) w_state_d = StDone;
      end
      StDone: if (load) w_state_d = StBusy;
      default: w_state_d = StIdle;
    endcase
  end

  // Round-control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Block/key capture and Feistel swap; state holds once done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l     <= '0;
      r_r     <= '0;
      r_key   <= '0;
      r_round <= '0;
    end else if (load) begin
      r_l     <= w_ip[63:32];
      r_r     <= w_ip[31:0];
      r_key   <= key_in;
      r_round <= '0;
    end else if (w_step) begin
      r_l     <= r_r;
      r_r     <= r_l ^ f_in;
      r_round <= r_round + 5'd1;
    end
  end

  des_expansion u_expansion (
    .i_half (r_r),
    .o_exp  (e_out)
  );

  assign w_preout = {r_r, r_l};

`ifdef DES_FINAL_PERM_EN
  for (genvar n = 1; n <= 64; n++) begin : g_fp
    localparam int unsigned Src = 64 - FP_TABLE[n-1];
    assign block_out[6'(64 - n)] = w_preout[6'(Src)];
  end
`else
  assign block_out = w_preout;
`endif

  assign l_out   = r_l;
  assign r_out   = r_r;
  assign key_out = r_key;
  assign round   = r_round;
  assign busy    = (r_state == StBusy);
  assign done    = (r_state == StDone);

endmodule

// File: tb/tb_des_round_core.sv
// Bench for des_round_core: directed DES vectors plus a randomized phase, checked
// against a behavioural DES model (tables, key schedule, S-boxes) kept in the bench.
module tb_des_round_core;

  localparam int ROUNDS = 16;

  localparam int TB_IP [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int TB_FP [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int TB_E [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int TB_P [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int TB_PC1 [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int TB_PC2 [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int TB_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int TB_S [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [63:0] block_in;
  logic [55:0] key_in;
  logic        step;
  logic [31:0] f_in;
  logic [31:0] l_out;
  logic [31:0] r_out;
  logic [47:0] e_out;
  logic [55:0] key_out;
  logic [4:0]  round;
  logic        busy;
  logic        done;
  logic [63:0] block_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: block halves, key, completed rounds, and whether a block was loaded.
  logic [31:0] ml, mr;
  logic [55:0] mkey;
  int          mround;
  bit          mactive;
  logic [47:0] ks [16];

  des_round_core #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .block_in  (block_in),
    .key_in    (key_in),
    .step      (step),
    .f_in      (f_in),
    .l_out     (l_out),
    .r_out     (r_out),
    .e_out     (e_out),
    .key_out   (key_out),
    .round     (round),
    .busy      (busy),
    .done      (done),
    .block_out (block_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DES bit pos (1-based) of an iw-bit value right-aligned in x.
  function automatic logic des_bit(input logic [63:0] x, input int iw, input int pos);
    logic [63:0] t;
    t = x >> (iw - pos);
    return t[0];
  endfunction

  function automatic logic [63:0] ref_ip(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int n = 0; n < 64; n++) y = {y[62:0], des_bit(x, 64, TB_IP[n])};
    return y;
  endfunction

  function automatic logic [63:0] ref_fp(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int n = 0; n < 64; n++) y = {y[62:0], des_bit(x, 64, TB_FP[n])};
    return y;
  endfunction

  function automatic logic [47:0] ref_e(input logic [31:0] x);
    logic [47:0] y = '0;
    for (int n = 0; n < 48; n++) y = {y[46:0], des_bit(64'(x), 32, TB_E[n])};
    return y;
  endfunction

  function automatic logic [31:0] ref_p(input logic [31:0] x);
    logic [31:0] y = '0;
    for (int n = 0; n < 32; n++) y = {y[30:0], des_bit(64'(x), 32, TB_P[n])};
    return y;
  endfunction

  function automatic logic [55:0] ref_pc1(input logic [63:0] x);
    logic [55:0] y = '0;
    for (int n = 0; n < 56; n++) y = {y[54:0], des_bit(x, 64, TB_PC1[n])};
    return y;
  endfunction

  function automatic logic [47:0] ref_pc2(input logic [55:0] x);
    logic [47:0] y = '0;
    for (int n = 0; n < 48; n++) y = {y[46:0], des_bit(64'(x), 56, TB_PC2[n])};
    return y;
  endfunction

  function automatic logic [31:0] ref_sbox(input logic [47:0] x);
    logic [31:0] y = '0;
    logic [47:0] t;
    logic [5:0]  v;
    int          idx;
    for (int i = 0; i < 8; i++) begin
      t   = x >> (42 - 6 * i);
      v   = t[5:0];
      idx = 32 * int'(v[5]) + 16 * int'(v[0]) + int'(v[4:1]);
      y   = {y[27:0], 4'(TB_S[i][idx])};
    end
    return y;
  endfunction

  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    return ref_p(ref_sbox(ref_e(r) ^ k));
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int s);
    return (x << s) | (x >> (28 - s));
  endfunction

  task automatic gen_subkeys(input logic [55:0] k56);
    logic [27:0] c, d;
    c = k56[55:28];
    d = k56[27:0];
    for (int i = 0; i < 16; i++) begin
      c     = rotl28(c, TB_SHIFT[i]);
      d     = rotl28(d, TB_SHIFT[i]);
      ks[i] = ref_pc2({c, d});
    end
  endtask

  function automatic logic [63:0] exp_block_out();
`ifdef DES_FINAL_PERM_EN
    return ref_fp({mr, ml});
`else
    return {mr, ml};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".l"},     64'(l_out),     64'(ml));
    chk({tag, ".r"},     64'(r_out),     64'(mr));
    chk({tag, ".e"},     64'(e_out),     64'(ref_e(mr)));
    chk({tag, ".key"},   64'(key_out),   64'(mkey));
    chk({tag, ".round"}, 64'(round),     64'(mround));
    chk({tag, ".busy"},  64'(busy),      64'(mactive && mround < ROUNDS));
    chk({tag, ".done"},  64'(done),      64'(mactive && mround == ROUNDS));
    chk({tag, ".bout"},  block_out,      exp_block_out());
  endtask

  task automatic model_reset();
    ml = '0; mr = '0; mkey = '0; mround = 0; mactive = 1'b0;
  endtask

  // Apply one clock edge's worth of behaviour to the reference state.
  task automatic model_edge(input logic ld, input logic st, input logic [31:0] f,
                            input logic [63:0] blk, input logic [55:0] k);
    logic [31:0] t;
    logic [63:0] p;
    if (ld) begin
      p       = ref_ip(blk);
      ml      = p[63:32];
      mr      = p[31:0];
      mkey    = k;
      mround  = 0;
      mactive = 1'b1;
    end else if (st && mactive && mround < ROUNDS) begin
      t      = ml;
      ml     = mr;
      mr     = t ^ f;
      mround = mround + 1;
    end
  endtask

  task automatic cycle(input logic ld, input logic st, input logic [31:0] f,
                       input logic [63:0] blk, input logic [55:0] k);
    load = ld; step = st; f_in = f; block_in = blk; key_in = k;
    @(posedge clk);
    model_edge(ld, st, f, blk, k);
    #1;
    load = 1'b0; step = 1'b0;
  endtask

  initial begin
    logic [55:0] k56;
    logic [31:0] sl, sr;
    logic [63:0] ct;

    rst_n = 1'b1; load = 1'b0; step = 1'b0; f_in = '0; block_in = '0; key_in = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #10;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Known first round of the textbook DES example.
    cycle(1'b1, 1'b0, 32'h0, 64'h0123456789ABCDEF, 56'hF0CCAAF556678F);
    chk("load.l", 64'(l_out), 64'hCC00CCFF);
    chk("load.r", 64'(r_out), 64'hF0AAF0AA);
    chk("load.e", 64'(e_out), 64'h7A15557A1555);
    chk("load.key", 64'(key_out), 64'hF0CCAAF556678F);
    chk("load.busy", 64'(busy), 64'd1);
    chk("load.round", 64'(round), 64'd0);
    check_all("load");
    cycle(1'b0, 1'b1, 32'h234AA9BB, 64'h0, 56'h0);
    chk("step1.l", 64'(l_out), 64'hF0AAF0AA);
    chk("step1.r", 64'(r_out), 64'hEF4A6544);
    chk("step1.round", 64'(round), 64'd1);
    check_all("step1");

    // Sixteen zero-f steps, then an extra step that must be ignored.
    cycle(1'b1, 1'b0, 32'h0, 64'h0123456789ABCDEF, 56'hF0CCAAF556678F);
    for (int i = 0; i < ROUNDS; i++) cycle(1'b0, 1'b1, 32'h0, 64'h0, 56'h0);
    chk("done.done", 64'(done), 64'd1);
    chk("done.busy", 64'(busy), 64'd0);
    chk("done.round", 64'(round), 64'd16);
    check_all("done");
    sl = l_out; sr = r_out;
    cycle(1'b0, 1'b1, 32'hDEADBEEF, 64'h0, 56'h0);
    chk("extra.l", 64'(l_out), 64'(sl));
    chk("extra.r", 64'(r_out), 64'(sr));
    check_all("extra");

    // load and step together: load wins.
    cycle(1'b0, 1'b1, 32'h0, 64'h0, 56'h0);
    cycle(1'b1, 1'b1, 32'h13579BDF, 64'hFEDCBA9876543210, 56'h123456789ABCDE);
    chk("ldst.round", 64'(round), 64'd0);
    chk("ldst.lr", {l_out, r_out}, ref_ip(64'hFEDCBA9876543210));
    check_all("ldst");

    // Full DES encryption with f supplied by the reference model.
    k56 = ref_pc1(64'h133457799BBCDFF1);
    gen_subkeys(k56);
    cycle(1'b1, 1'b0, 32'h0, 64'h0123456789ABCDEF, k56);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, ref_f(mr, ks[i]), 64'h0, 56'h0);
      check_all("des_round");
    end
    ct = 64'h85E813540F0AB405;
`ifdef DES_FINAL_PERM_EN
    chk("des.block_out", block_out, ct);
`else
    chk("des.block_out", block_out, ref_ip(ct));
`endif

    // Randomized loads/steps with occasional back-to-back loads.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), $urandom(),
            {$urandom(), $urandom()}, {24'($urandom()), $urandom()});
      check_all("rand");
    end

    // Asynchronous reset mid-block: outputs clear with no clock edge.
    cycle(1'b1, 1'b0, 32'h0, 64'hA5A5A5A55A5A5A5A, 56'hABCDEF01234567);
    cycle(1'b0, 1'b1, 32'h0F0F0F0F, 64'h0, 56'h0);
    cycle(1'b0, 1'b1, 32'hF0F0F0F0, 64'h0, 56'h0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 32'h11111111, 64'h0, 56'h0);
    check_all("post_rst_step");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
